mux_rr_nto1: RTL and testbench

Parametrised N:1 multiplexer with a registered output and valid/ready flow control on both sides. It is the next generation of the 8:1 bit mux: the data width and channel count are parameters, and it adds a round-robin scan mode alongside fixed-select. It sits between several producer channels and one downstream consumer. Each cycle it selects one valid channel, moves that channel's word into the output register and acknowledges it.

---
 rtl/mux_rr_nto1_pkg.sv | 19 +
 rtl/mux_rr_nto1_rr_pick.sv | 55 +++++
 rtl/mux_rr_nto1.sv | 136 +++++++++++++
 tb/tb_mux_rr_nto1.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_nto1_pkg.sv
// Shared definitions for the round-robin N:1 multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input.
//   clog2_min1()         : index width for n channels, never less than 1 bit.
package mux_rr_nto1_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // $clog2 gives 0 for n<=1; a channel-index field must still be one bit wide.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_rr_nto1_rr_pick.sv
// Round-robin picker: finds the first asserted request at or after 'ptr',
// wrapping past NCH-1 back to 0. Purely combinational.
// Ports:
//   req     [NCH]  request vector
//   ptr     [SELW] highest-priority channel, must be < NCH
//   gnt_vld        any request asserted
//   gnt_idx [SELW] winning channel index (0 when gnt_vld=0)
module mux_rr_nto1_rr_pick
    import mux_rr_nto1_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int SELW = clog2_min1(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);

    localparam logic [SELW:0] NCH_EXT = (SELW+1)'(NCH);

    logic [2*NCH-1:0] req_dbl;
    logic [NCH-1:0]   req_rot;
    logic [SELW-1:0]  off;
    logic [SELW:0]    sum;

    // Rotate so that channel 'ptr' lands at bit 0; the doubled vector
    // supplies the wrapped-around channels above it.
    always_comb begin
        req_dbl = {req, req};
        req_rot = NCH'(req_dbl >> ptr);
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        off = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = SELW'(i);
            end
        end
    end

    // Un-rotate: add the pointer back, modulo NCH. ptr+off <= 2*NCH-2,
    // so one conditional subtract is enough.
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NCH_EXT) begin
            sum = sum - NCH_EXT;
        end
        gnt_vld = |req;
        gnt_idx = gnt_vld ? sum[SELW-1:0] : '0;
    end

endmodule

// File: rtl/mux_rr_nto1.sv
// N:1 multiplexer with a registered output and valid/ready flow control.
// Mode 0 forwards the channel chosen by 'sel'; mode 1 scans the channels
// round-robin starting after the last channel served.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   din      [NCH*WIDTH]  packed channel data, channel i at [i*WIDTH +: WIDTH]
//   ch_valid [NCH]        per-channel valid
//   ch_ready [NCH]        per-channel accept (combinational, one-hot or zero)
//   mode                  MODE_FIXED / MODE_RR
//   sel      [SELW]       channel used in fixed mode
//   dout     [WIDTH]      registered output word
//   dout_ch  [SELW]       channel that supplied dout
//   dout_valid            output register holds a word
//   out_ready             consumer takes dout this cycle
module mux_rr_nto1
    import mux_rr_nto1_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    parameter int SELW  = clog2_min1(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [NCH-1:0]       ch_valid,
    output logic [NCH-1:0]       ch_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     dout,
    output logic [SELW-1:0]      dout_ch,
    output logic                 dout_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SELW-1:0]  dout_ch_q, dout_ch_d;
    logic             dout_valid_q, dout_valid_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             load;
    logic             fix_vld;
    logic             rr_vld;
    logic [SELW-1:0]  rr_idx;
    logic             grant_vld;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_word;

    mux_rr_nto1_rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_pick (
        .req     (ch_valid),
        .ptr     (rr_ptr_q),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    assign load = !dout_valid_q || out_ready;

    // Decoding sel against each real channel means an out-of-range sel
    // (possible when NCH is not a power of two) matches nothing.
    always_comb begin
        fix_vld = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == SELW'(i)) begin
                fix_vld = ch_valid[i];
            end
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            grant_vld = rr_vld;
            grant     = rr_idx;
        end else begin
            grant_vld = fix_vld;
            grant     = sel;
        end
    end

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == SELW'(i)) begin
                grant_word = din[i*WIDTH +: WIDTH];
            end
        end
    end

    // While in reset the output register reads empty (load=1), so ready
    // must be gated by rst_n explicitly.
    always_comb begin
        ch_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_ready[i] = rst_n && load && grant_vld && (grant == SELW'(i));
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        rr_ptr_d     = rr_ptr_q;
        if (load) begin
            if (grant_vld) begin
                dout_d       = grant_word;
                dout_ch_d    = grant;
                dout_valid_d = 1'b1;
                if (mode == MODE_RR) begin
                    rr_ptr_d = (grant == SELW'(NCH - 1)) ? '0 : grant + SELW'(1);
                end
            end else begin
                dout_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            rr_ptr_q     <= '0;
        end else begin
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux_rr_nto1.sv
module tb_mux_rr_nto1;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [63:0]  din = '0;
    logic [7:0]   ch_valid = '0;
    logic [7:0]   ch_ready;
    logic         mode = 1'b0;
    logic [2:0]   sel = '0;
    logic [7:0]   dout;
    logic [2:0]   dout_ch;
    logic         dout_valid;
    logic         out_ready = 1'b0;

    logic [47:0]  din6 = '0;
    logic [5:0]   valid6 = '0;
    logic [5:0]   ready6;
    logic         mode6 = 1'b0;
    logic [2:0]   sel6 = '0;
    logic [7:0]   dout6;
    logic [2:0]   ch6;
    logic         dv6;
    logic         ordy6 = 1'b0;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [7:0] m_dout = '0;
    int         m_ch = 0;
    bit         m_vld = 0;
    int         m_ptr = 0;

    int rr_exp [6] = '{1, 3, 6, 1, 3, 6};

    always #5 clk = ~clk;

    mux_rr_nto1 #(.WIDTH(8), .NCH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .din(din), .ch_valid(ch_valid),
        .ch_ready(ch_ready), .mode(mode), .sel(sel), .dout(dout),
        .dout_ch(dout_ch), .dout_valid(dout_valid), .out_ready(out_ready)
    );

    mux_rr_nto1 #(.WIDTH(8), .NCH(6)) u6 (
        .clk(clk), .rst_n(rst_n), .din(din6), .ch_valid(valid6),
        .ch_ready(ready6), .mode(mode6), .sel(sel6), .dout(dout6),
        .dout_ch(ch6), .dout_valid(dv6), .out_ready(ordy6)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic [7:0] v);
        din[c*8 +: 8] = v;
    endtask

    // Which channel the spec's rules would pick right now.
    task automatic model_grant(output bit v, output int g);
        v = 0;
        g = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < N && ch_valid[sel]) begin
                v = 1;
                g = int'(sel);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!v && ch_valid[c]) begin
                    v = 1;
                    g = c;
                end
            end
        end
    endtask

    // Called at posedge+1 with inputs already applied; returns at next posedge+1.
    task automatic cycle(input string tag);
        bit v;
        int g;
        logic [7:0] er;
        bit ld;
        #1;
        model_grant(v, g);
        ld = !m_vld || out_ready;
        er = '0;
        if (ld && v) er[g] = 1'b1;
        chk({tag, ".ch_ready"}, 64'(ch_ready), 64'(er));
        @(posedge clk);
        if (ld) begin
            if (v) begin
                m_dout = din[g*8 +: 8];
                m_ch   = g;
                m_vld  = 1;
                if (mode) m_ptr = (g + 1) % N;
            end else begin
                m_vld = 0;
            end
        end
        #1;
        chk({tag, ".dout"},       64'(dout),       64'(m_dout));
        chk({tag, ".dout_ch"},    64'(dout_ch),    64'(m_ch));
        chk({tag, ".dout_valid"}, 64'(dout_valid), 64'(m_vld));
        chk({tag, ".rr_ptr"},     64'(u8.rr_ptr_q), 64'(m_ptr));
    endtask

    initial begin
        din = {$urandom, $urandom};
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.dout",       64'(dout),       64'h0);
        chk("rst.dout_ch",    64'(dout_ch),    64'h0);
        chk("rst.dout_valid", 64'(dout_valid), 64'h0);

        // fixed select
        mode = 1'b0; sel = 3'd5; set_ch(5, 8'hA5); ch_valid = 8'hFF; out_ready = 1'b1;
        cycle("fix5");
        chk("fix5.const", 64'(dout), 64'hA5);
        sel = 3'd2; set_ch(2, 8'h3C);
        cycle("fix2");
        chk("fix2.const", 64'(dout), 64'h3C);
        chk("fix2.ch",    64'(dout_ch), 64'd2);

        // reset asserted mid-stream, off the clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.dout",       64'(dout),       64'h0);
        chk("midrst.dout_ch",    64'(dout_ch),    64'h0);
        chk("midrst.dout_valid", 64'(dout_valid), 64'h0);
        chk("midrst.ch_ready",   64'(ch_ready),   64'h0);
        m_dout = '0; m_ch = 0; m_vld = 0; m_ptr = 0;
        ch_valid = '0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // round-robin order, then wrap from 7 to 0
        mode = 1'b1; ch_valid = 8'b0100_1010;
        for (int k = 0; k < 6; k++) begin
            cycle("rr");
            chk("rr.order", 64'(dout_ch), 64'(rr_exp[k]));
        end
        ch_valid = 8'b1000_0001;
        cycle("wrap7");
        chk("wrap.first", 64'(dout_ch), 64'd7);
        cycle("wrap0");
        chk("wrap.second", 64'(dout_ch), 64'd0);

        // backpressure
        mode = 1'b0; sel = 3'd1; ch_valid = 8'h02; set_ch(1, 8'h11);
        cycle("bp.load");
        chk("bp.load.const", 64'(dout), 64'h11);
        mode = 1'b1; ch_valid = 8'hFF; out_ready = 1'b0; set_ch(1, 8'h22);
        for (int k = 0; k < 3; k++) begin
            cycle("bp.stall");
            chk("bp.hold", 64'(dout), 64'h11);
            chk("bp.ptr",  64'(u8.rr_ptr_q), 64'd1);
        end
        out_ready = 1'b1;
        cycle("bp.rel");
        chk("bp.rel.dout", 64'(dout), 64'h22);
        cycle("bp.next");
        chk("bp.nobubble", 64'(dout_valid), 64'd1);
        chk("bp.next.ch",  64'(dout_ch),    64'd2);

        // empty input in both modes
        ch_valid = '0; mode = 1'b0;
        cycle("empty0");
        chk("empty0.valid", 64'(dout_valid), 64'd0);
        mode = 1'b1;
        cycle("empty1");
        chk("empty1.valid", 64'(dout_valid), 64'd0);
        chk("empty1.ptr",   64'(u8.rr_ptr_q), 64'd3);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            mode      = 1'($urandom);
            sel       = 3'($urandom);
            ch_valid  = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            din       = {$urandom, $urandom};
            cycle("rand");
        end

        // NCH=6 with an out-of-range select
        mode6 = 1'b0; sel6 = 3'd0; valid6 = 6'h3F; din6 = {$urandom, $urandom}; din6[7:0] = 8'h5A; ordy6 = 1'b1;
        #1;
        chk("n6.rdy0", 64'(ready6), 64'h01);
        @(posedge clk); #1;
        chk("n6.dv", 64'(dv6), 64'd1);
        chk("n6.dout", 64'(dout6), 64'h5A);
        sel6 = 3'd5;
        #1;
        chk("n6.rdy5", 64'(ready6), 64'h20);
        sel6 = 3'd7; ordy6 = 1'b0;
        #1;
        chk("n6.oor.stall.rdy", 64'(ready6), 64'h0);
        @(posedge clk); #1;
        chk("n6.oor.held", 64'(dv6), 64'd1);
        ordy6 = 1'b1;
        #1;
        chk("n6.oor.rdy", 64'(ready6), 64'h0);
        @(posedge clk); #1;
        chk("n6.oor.drain", 64'(dv6), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
